// File: rtl/dst_hazard_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dst_hazard_pipe
//  Purpose  : Carries destination register, write-enable and Tnew through the
//             E, M and W pipeline registers of a 5-stage MIPS pipeline, and
//             derives the D-stage stall request and rs/rt forwarding selects
//             from that in-flight state.
//  Revision : 1.0  initial release
// ============================================================================
module dst_hazard_pipe #(
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,       // synchronous, active low
    input  logic [REG_W-1:0]  d_dst,
    input  logic              d_regwrite,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic [REG_W-1:0]  e_dst,
    output logic [REG_W-1:0]  m_dst,
    output logic [REG_W-1:0]  w_dst,
    output logic              e_regwrite,
    output logic              m_regwrite,
    output logic              w_regwrite,
    output logic [TNEW_W-1:0] e_tnew,
    output logic [TNEW_W-1:0] m_tnew
);

    localparam logic [1:0]        c_FWD_RF  = 2'd0;
    localparam logic [1:0]        c_FWD_E   = 2'd1;
    localparam logic [1:0]        c_FWD_M   = 2'd2;
    localparam logic [1:0]        c_FWD_W   = 2'd3;
    localparam logic [TNEW_W-1:0] c_TNEW_0  = '0;
    localparam logic [TNEW_W-1:0] c_TNEW_1  = TNEW_W'(1);
    localparam logic [REG_W-1:0]  c_REG_0   = '0;

    // Pipeline stage state
    logic [REG_W-1:0]  r_e_dst,  r_m_dst,  r_w_dst;
    logic              r_e_we,   r_m_we,   r_w_we;
    logic [TNEW_W-1:0] r_e_tnew, r_m_tnew;

    // Stage-match terms against the D-stage sources
    logic w_e_rs, w_m_rs, w_w_rs;
    logic w_e_rt, w_m_rt, w_w_rt;
    logic w_stall;
    logic [1:0] w_fwd_rs, w_fwd_rt;
    logic [TNEW_W-1:0] w_e_tnew_dec;

    assign w_e_rs = r_e_we && (r_e_dst == d_rs);
    assign w_m_rs = r_m_we && (r_m_dst == d_rs);
    assign w_w_rs = r_w_we && (r_w_dst == d_rs);
    assign w_e_rt = r_e_we && (r_e_dst == d_rt);
    assign w_m_rt = r_m_we && (r_m_dst == d_rt);
    assign w_w_rt = r_w_we && (r_w_dst == d_rt);

    // Saturating decrement of Tnew as the instruction moves from E to M
    assign w_e_tnew_dec = (r_e_tnew != c_TNEW_0) ? (r_e_tnew - c_TNEW_1) : c_TNEW_0;

    // Stall when a producer in E or M cannot deliver before the source is used;
    // W always has Tnew 0, so it never contributes.
    always_comb begin
        w_stall = 1'b0;
        if (w_e_rs && (r_e_tnew > d_tuse_rs)) w_stall = 1'b1;
        if (w_m_rs && (r_m_tnew > d_tuse_rs)) w_stall = 1'b1;
        if (w_e_rt && (r_e_tnew > d_tuse_rt)) w_stall = 1'b1;
        if (w_m_rt && (r_m_tnew > d_tuse_rt)) w_stall = 1'b1;
    end

    // rs forwarding: youngest matching producer wins; a younger match that is
    // not ready yet falls back to the regfile rather than an older stale value.
    always_comb begin
        w_fwd_rs = c_FWD_RF;
        if (w_e_rs) begin
            w_fwd_rs = (r_e_tnew == c_TNEW_0) ? c_FWD_E : c_FWD_RF;
        end else if (w_m_rs) begin
            w_fwd_rs = (r_m_tnew == c_TNEW_0) ? c_FWD_M : c_FWD_RF;
        end else if (w_w_rs) begin
            w_fwd_rs = c_FWD_W;
        end
    end

    // rt forwarding with the same priority rules as rs
    always_comb begin
        w_fwd_rt = c_FWD_RF;
        if (w_e_rt) begin
            w_fwd_rt = (r_e_tnew == c_TNEW_0) ? c_FWD_E : c_FWD_RF;
        end else if (w_m_rt) begin
            w_fwd_rt = (r_m_tnew == c_TNEW_0) ? c_FWD_M : c_FWD_RF;
        end else if (w_w_rt) begin
            w_fwd_rt = c_FWD_W;
        end
    end

    // Advance E/M/W every cycle; a stall only replaces the E entry with a bubble.
    // Write-enable is dropped for $0 so it never matches a source.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e_dst  <= '0;
            r_e_we   <= 1'b0;
            r_e_tnew <= '0;
            r_m_dst  <= '0;
            r_m_we   <= 1'b0;
            r_m_tnew <= '0;
            r_w_dst  <= '0;
            r_w_we   <= 1'b0;
        end else begin
            if (w_stall) begin
                r_e_dst  <= '0;
                r_e_we   <= 1'b0;
                r_e_tnew <= '0;
            end else begin
                r_e_dst  <= d_dst;
                r_e_we   <= d_regwrite && (d_dst != c_REG_0);
                r_e_tnew <= d_tnew;
            end
            r_m_dst  <= r_e_dst;
            r_m_we   <= r_e_we && (r_e_dst != c_REG_0);
            r_m_tnew <= w_e_tnew_dec;
            r_w_dst  <= r_m_dst;
            r_w_we   <= r_m_we && (r_m_dst != c_REG_0);
        end
    end

    assign stall      = w_stall;
    assign fwd_rs_sel = w_fwd_rs;
    assign fwd_rt_sel = w_fwd_rt;
    assign e_dst      = r_e_dst;
    assign m_dst      = r_m_dst;
    assign w_dst      = r_w_dst;
    assign e_regwrite = r_e_we;
    assign m_regwrite = r_m_we;
    assign w_regwrite = r_w_we;
    assign e_tnew     = r_e_tnew;
    assign m_tnew     = r_m_tnew;

endmodule
`default_nettype wire

// File: tb/tb_dst_hazard_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dst_hazard_pipe
//  Purpose  : Self-checking bench for dst_hazard_pipe: directed vector table
//             covering reset, load-use, ALU forwarding, priority, $0 and
//             unused-operand cases, then randomized traffic against a
//             stage-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dst_hazard_pipe;

    logic       clk;
    logic       reset;
    logic [4:0] d_dst, d_rs, d_rt;
    logic       d_regwrite;
    logic [1:0] d_tnew, d_tuse_rs, d_tuse_rt;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [4:0] e_dst, m_dst, w_dst;
    logic       e_regwrite, m_regwrite, w_regwrite;
    logic [1:0] e_tnew, m_tnew;

    int total;
    int bad;

    dst_hazard_pipe #(.REG_W(5), .TNEW_W(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .d_dst      (d_dst),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .e_dst      (e_dst),
        .m_dst      (m_dst),
        .w_dst      (w_dst),
        .e_regwrite (e_regwrite),
        .m_regwrite (m_regwrite),
        .w_regwrite (w_regwrite),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed step: inputs for this cycle, and what the DUT must show
    // before the edge (combinational outputs plus state left by earlier rows).
    typedef struct {
        logic       rst_n;
        logic [4:0] dst;
        logic       we;
        logic [1:0] tn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] urs;
        logic [1:0] urt;
        logic       x_st;
        logic [1:0] x_fs;
        logic [1:0] x_ft;
        logic [4:0] x_ed;
        logic       x_ew;
        logic [1:0] x_et;
        logic [4:0] x_md;
        logic       x_mw;
        logic [1:0] x_mt;
        logic [4:0] x_wd;
        logic       x_ww;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_n, input logic [4:0] dst, input logic we, input logic [1:0] tn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs, input logic [1:0] urt,
        input logic x_st, input logic [1:0] x_fs, input logic [1:0] x_ft,
        input logic [4:0] x_ed, input logic x_ew, input logic [1:0] x_et,
        input logic [4:0] x_md, input logic x_mw, input logic [1:0] x_mt,
        input logic [4:0] x_wd, input logic x_ww);
        vec_t v;
        v.rst_n = rst_n; v.dst = dst; v.we = we; v.tn = tn;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.x_st = x_st; v.x_fs = x_fs; v.x_ft = x_ft;
        v.x_ed = x_ed; v.x_ew = x_ew; v.x_et = x_et;
        v.x_md = x_md; v.x_mw = x_mw; v.x_mt = x_mt;
        v.x_wd = x_wd; v.x_ww = x_ww;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // ---------------- reference model: list of in-flight stages ----------------
    // Index 0 = E, 1 = M, 2 = W (oldest). W Tnew is always 0.
    logic [4:0] md_dst [3];
    logic       md_we  [3];
    logic [1:0] md_tn  [3];

    function automatic logic mdl_stall();
        logic s;
        s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (md_we[k] && md_dst[k] == d_rs && int'(md_tn[k]) > int'(d_tuse_rs)) s = 1'b1;
            if (md_we[k] && md_dst[k] == d_rt && int'(md_tn[k]) > int'(d_tuse_rt)) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [1:0] mdl_fwd(input logic [4:0] src);
        for (int k = 0; k < 3; k++) begin
            if (md_we[k] && md_dst[k] == src) begin
                if (md_tn[k] == 2'd0) return 2'(k + 1);
                return 2'd0;
            end
        end
        return 2'd0;
    endfunction

    task automatic mdl_clock();
        logic st;
        st = mdl_stall();
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                md_dst[k] = '0; md_we[k] = 1'b0; md_tn[k] = '0;
            end
        end else begin
            md_dst[2] = md_dst[1]; md_we[2] = md_we[1]; md_tn[2] = 2'd0;
            md_dst[1] = md_dst[0]; md_we[1] = md_we[0];
            md_tn[1]  = (md_tn[0] == 2'd0) ? 2'd0 : 2'(int'(md_tn[0]) - 1);
            if (st) begin
                md_dst[0] = '0; md_we[0] = 1'b0; md_tn[0] = '0;
            end else begin
                md_dst[0] = d_dst; md_we[0] = d_regwrite && (d_dst != 5'd0); md_tn[0] = d_tnew;
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0; d_dst = '0; d_regwrite = 1'b0; d_tnew = '0;
        d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;

        //           rst dst we tn  rs  rt urs urt  st fs ft  ed ew et  md mw mt  wd ww
        vecs.push_back(mk(0,  8, 1, 1,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0)); // 0 reset
        vecs.push_back(mk(0,  8, 1, 1,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0)); // 1 reset
        vecs.push_back(mk(1,  8, 1, 1,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0)); // 2 release
        vecs.push_back(mk(1,  0, 0, 0,  0,  0, 3, 3,  0, 0, 0,  8, 1, 1,  0, 0, 0,  0, 0)); // 3 e_dst=8
        vecs.push_back(mk(1,  9, 1, 2,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  8, 1, 0,  0, 0)); // 4 lw $9
        vecs.push_back(mk(1,  0, 0, 0,  9,  0, 0, 3,  1, 0, 0,  9, 1, 2,  0, 0, 0,  8, 1)); // 5 load-use
        vecs.push_back(mk(1,  0, 0, 0,  9,  0, 0, 3,  1, 0, 0,  0, 0, 0,  9, 1, 1,  0, 0)); // 6 still stalled
        vecs.push_back(mk(1,  0, 0, 0,  9,  0, 0, 3,  0, 3, 0,  0, 0, 0,  0, 0, 0,  9, 1)); // 7 fwd from W
        vecs.push_back(mk(1, 10, 1, 1,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0)); // 8 addu $10
        vecs.push_back(mk(1,  0, 0, 0,  0, 10, 3, 1,  0, 0, 0, 10, 1, 1,  0, 0, 0,  0, 0)); // 9 no stall
        vecs.push_back(mk(1,  0, 0, 0,  0, 10, 3, 1,  0, 0, 2,  0, 0, 0, 10, 1, 0,  0, 0)); // 10 fwd from M
        vecs.push_back(mk(1, 11, 1, 1,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0, 10, 1)); // 11 $11
        vecs.push_back(mk(1, 11, 1, 1,  0,  0, 3, 3,  0, 0, 0, 11, 1, 1,  0, 0, 0,  0, 0)); // 12 $11 again
        vecs.push_back(mk(1,  0, 0, 0, 11,  0, 3, 3,  0, 0, 0, 11, 1, 1, 11, 1, 0,  0, 0)); // 13 E blocks M
        vecs.push_back(mk(1, 11, 1, 0, 11,  0, 3, 3,  0, 2, 0,  0, 0, 0, 11, 1, 0, 11, 1)); // 14 M over W
        vecs.push_back(mk(1,  0, 0, 0, 11,  0, 3, 3,  0, 1, 0, 11, 1, 0,  0, 0, 0, 11, 1)); // 15 E over W
        vecs.push_back(mk(1,  0, 1, 2,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0, 11, 1, 0,  0, 0)); // 16 write $0
        vecs.push_back(mk(1,  0, 0, 0,  0,  0, 0, 3,  0, 0, 0,  0, 0, 2,  0, 0, 0, 11, 1)); // 17 $0 guard
        vecs.push_back(mk(1, 12, 1, 2,  0,  0, 3, 3,  0, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0)); // 18 lw $12
        vecs.push_back(mk(1,  0, 0, 0,  0, 12, 3, 3,  0, 0, 0, 12, 1, 2,  0, 0, 0,  0, 0)); // 19 rt unused
        vecs.push_back(mk(1,  0, 0, 0,  0, 12, 3, 0,  1, 0, 0,  0, 0, 0, 12, 1, 1,  0, 0)); // 20 rt stall
        vecs.push_back(mk(0,  0, 0, 0,  0, 12, 3, 0,  0, 0, 3,  0, 0, 0,  0, 0, 0, 12, 1)); // 21 reset mid-op
        vecs.push_back(mk(1,  0, 0, 0,  0, 12, 3, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0)); // 22 flushed

        // Put the pipeline into a known state before the table starts.
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst_n;  d_dst = vecs[i].dst; d_regwrite = vecs[i].we;
            d_tnew = vecs[i].tn;    d_rs = vecs[i].rs;   d_rt = vecs[i].rt;
            d_tuse_rs = vecs[i].urs; d_tuse_rt = vecs[i].urt;
            #2;
            chk("stall",      i, {7'd0, stall},      {7'd0, vecs[i].x_st});
            chk("fwd_rs_sel", i, {6'd0, fwd_rs_sel}, {6'd0, vecs[i].x_fs});
            chk("fwd_rt_sel", i, {6'd0, fwd_rt_sel}, {6'd0, vecs[i].x_ft});
            chk("e_dst",      i, {3'd0, e_dst},      {3'd0, vecs[i].x_ed});
            chk("e_regwrite", i, {7'd0, e_regwrite}, {7'd0, vecs[i].x_ew});
            chk("e_tnew",     i, {6'd0, e_tnew},     {6'd0, vecs[i].x_et});
            chk("m_dst",      i, {3'd0, m_dst},      {3'd0, vecs[i].x_md});
            chk("m_regwrite", i, {7'd0, m_regwrite}, {7'd0, vecs[i].x_mw});
            chk("m_tnew",     i, {6'd0, m_tnew},     {6'd0, vecs[i].x_mt});
            chk("w_dst",      i, {3'd0, w_dst},      {3'd0, vecs[i].x_wd});
            chk("w_regwrite", i, {7'd0, w_regwrite}, {7'd0, vecs[i].x_ww});
            @(posedge clk);
            #1;
        end

        // Randomized traffic: start from a reset so the model state is known.
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            md_dst[k] = '0; md_we[k] = 1'b0; md_tn[k] = '0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 49) != 0);
            d_dst      = 5'($urandom_range(0, 3));
            d_regwrite = 1'($urandom_range(0, 1));
            d_tnew     = 2'($urandom_range(0, 2));
            d_rs       = 5'($urandom_range(0, 3));
            d_rt       = 5'($urandom_range(0, 3));
            d_tuse_rs  = 2'($urandom_range(0, 3));
            d_tuse_rt  = 2'($urandom_range(0, 3));
            #2;
            chk("rnd_stall", i, {7'd0, stall},      {7'd0, mdl_stall()});
            chk("rnd_fwd_rs", i, {6'd0, fwd_rs_sel}, {6'd0, mdl_fwd(d_rs)});
            chk("rnd_fwd_rt", i, {6'd0, fwd_rt_sel}, {6'd0, mdl_fwd(d_rt)});
            chk("rnd_e", i, {e_regwrite, e_tnew, e_dst}, {md_we[0], md_tn[0], md_dst[0]});
            chk("rnd_m", i, {m_regwrite, m_tnew, m_dst}, {md_we[1], md_tn[1], md_dst[1]});
            chk("rnd_w", i, {2'd0, w_regwrite, w_dst},   {2'd0, md_we[2], md_dst[2]});
            @(posedge clk);
            mdl_clock();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dst_hazard_pipe.md
Name: dst_hazard_pipe

Overview:
- Carries each instruction's destination register number, write-enable and Tnew (cycles until its result exists) through the E, M and W pipeline registers.
- Input comes from the decode-side destination select (Rt/Rd/31 choice), held in D.
- Compares D-stage source registers against in-flight destinations.
- Produces the stall request and the D-stage forwarding selects for the hazard/forward logic of the 5-stage MIPS pipeline.

Parameters:
- REG_W, 5, register-number width
- TNEW_W, 2, width of the Tnew/Tuse fields

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous active-low reset; reset==0 at a rising edge clears all state
- d_dst  input  REG_W  destination register of the instruction in D (already Rt/Rd/31 selected)
- d_regwrite  input  1  instruction in D writes the GPR file
- d_tnew  input  TNEW_W  Tnew of the D instruction as it will be in E (ALU=1, load=2, no-result=0)
- d_rs  input  REG_W  rs of the D instruction
- d_rt  input  REG_W  rt of the D instruction
- d_tuse_rs  input  TNEW_W  cycles until rs is needed; 3 = not used
- d_tuse_rt  input  TNEW_W  cycles until rt is needed; 3 = not used
- stall  output  1  combinational; hold PC and IF/ID, bubble into E
- fwd_rs_sel  output  2  combinational; 0 = regfile, 1 = from E, 2 = from M, 3 = from W
- fwd_rt_sel  output  2  same encoding for rt
- e_dst, m_dst, w_dst  output  REG_W  registered destination per stage
- e_regwrite, m_regwrite, w_regwrite  output  1  registered write-enable per stage
- e_tnew, m_tnew  output  TNEW_W  registered Tnew of E and M

Behaviour:
- Reset (reset==0 at posedge): all e_/m_/w_ outputs = 0. stall and fwd selects then evaluate to 0.
- Capture rule: a stage's regwrite is stored as (regwrite_in && dst_in != 0). Writes to $0 never create hazards or forwards. dst is stored unmodified.
- E capture each cycle:
  - stall==0: E <= {d_dst, d_regwrite, d_tnew}.
  - stall==1: E <= bubble {0, 0, 0}.
- M capture each cycle: M <= {e_dst, e_regwrite, sat_dec(e_tnew)}, where sat_dec(x) = x-1 if x>0, else 0.
- W capture each cycle: W <= {m_dst, m_regwrite}. W Tnew is implicitly 0.
- M and W always advance; stall never freezes them. No internal flush.
- Stage-match definition: E/M/W matches source s when regwrite==1 and dst==s (s != 0 is guaranteed by the capture rule).
- stall = any of:
  - E matches rs and e_tnew > d_tuse_rs
  - M matches rs and m_tnew > d_tuse_rs
  - the same two terms for rt with d_tuse_rt
- Tuse=3 never stalls (Tnew max 2).
- Forward select for s, priority E > M > W:
  - 1 if E matches and e_tnew==0
  - else 2 if M matches and m_tnew==0
  - else 3 if W matches
  - else 0
- Forward selects are computed even when stall==1. The consumer ignores them while stalling.
- A younger match with nonzero Tnew blocks older-stage forwarding: if E matches with e_tnew>0, the select is 0, not M/W. The stall covers that case whenever Tuse requires it.
- Latency: registered outputs change 1 cycle after inputs; stall/fwd are same-cycle combinational from registered state and D inputs.
- Reset mid-operation: all in-flight entries are discarded on that edge; stall drops on the next evaluation.

Test Plan:
- Reset: hold reset=0 two cycles with d_regwrite=1, d_dst=8 -> all e_/m_/w_ = 0, stall=0, fwd sels=0; release -> e_dst=8 next edge.
- Load-use: lw writes $9 (tnew=2) enters E; D has rs=9, tuse_rs=0 -> stall=1 that cycle.
  - Next cycle: E is a bubble, M holds $9 with m_tnew=1, stall=1.
  - Next cycle: stall=0, fwd_rs_sel=3.
- ALU forward: addu $10 (tnew=1) followed by a user with rt=10, tuse_rt=1 -> no stall.
  - After one edge (M, m_tnew=0), a D reader of rt=10 sees fwd_rt_sel=2.
- Priority: $11 written in W, then again in M (tnew=0), D rs=11 -> fwd_rs_sel=2. With $11 also in E, e_tnew=0 -> 1.
- $0 guard: d_dst=0, d_regwrite=1, then D rs=0 tuse=0 -> e_regwrite=0, stall=0, fwd_rs_sel=0.
- Unused operand: E holds $12 with tnew=2, D rt=12, tuse_rt=3 -> stall=0, fwd_rt_sel=0.
